// File: rtl/mips_hazard_unit.sv
// mips_hazard_unit
// Hazard and forwarding controller for a 5-stage MIPS pipeline, located in ID.
// It forwards operands, stalls on load-use and MDU hazards, flushes on a taken
// branch, tracks how long the multiply/divide unit stays busy, and counts stall
// cycles with a saturating counter.
//
// Optional feature: define HAZARD_WB_FORWARD_EN to also forward from WB
// (select 2'b11). When it is undefined, WB is ignored because the register
// file is write-first.
//
// Ports:
//   clk_i, rst_i                    clock and synchronous active-high reset
//   rs_i, rt_i, rs_used_i, rt_used_i
//                                   ID source registers and their "used" flags
//   write_reg_*_i, RegWrite_*_i     destination register and write enable for EX/MEM/WB
//   MemRead_EX_i                    the instruction in EX is a load
//   mdu_start_i, mdu_use_i          ID instruction is mult/div, or reads HI/LO
//   branch_taken_i                  the branch in EX resolved taken
//   stall_cnt_clr_i                 clears the stall counter
//   stall_o, flush_IFID_o, flush_IDEX_o
//                                   pipeline control (combinational)
//   Asrc_o, Bsrc_o                  forwarding selects (combinational)
//   mdu_busy_o, stall_cnt_o         registered status

module mips_hazard_unit #(
    parameter int unsigned REG_AW  = 5,
    parameter int unsigned MDU_LAT = 4,
    parameter int unsigned CNT_W   = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [REG_AW-1:0] rs_i,
    input  logic [REG_AW-1:0] rt_i,
    input  logic              rs_used_i,
    input  logic              rt_used_i,
    input  logic [REG_AW-1:0] write_reg_EX_i,
    input  logic [REG_AW-1:0] write_reg_MEM_i,
    input  logic [REG_AW-1:0] write_reg_WB_i,
    input  logic              RegWrite_EX_i,
    input  logic              RegWrite_MEM_i,
    input  logic              RegWrite_WB_i,
    input  logic              MemRead_EX_i,
    input  logic              mdu_start_i,
    input  logic              mdu_use_i,
    input  logic              branch_taken_i,
    input  logic              stall_cnt_clr_i,
    output logic              stall_o,
    output logic              flush_IFID_o,
    output logic              flush_IDEX_o,
    output logic [1:0]        Asrc_o,
    output logic [1:0]        Bsrc_o,
    output logic              mdu_busy_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    localparam int unsigned BUSY_W = $clog2(MDU_LAT + 1);

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_EX  = 2'b01;
    localparam logic [1:0] SEL_MEM = 2'b10;
`ifdef HAZARD_WB_FORWARD_EN
    localparam logic [1:0] SEL_WB  = 2'b11;
`endif

    logic [BUSY_W-1:0] busy_cnt_d, busy_cnt_q;
    logic [CNT_W-1:0]  stall_cnt_d, stall_cnt_q;

    // A stage is a forwarding candidate only if it writes a non-zero register.
    logic ex_wr_c, mem_wr_c;
    logic load_use_c, mdu_haz_c, busy_c;

    assign ex_wr_c  = RegWrite_EX_i  && (write_reg_EX_i  != '0);
    assign mem_wr_c = RegWrite_MEM_i && (write_reg_MEM_i != '0);

`ifdef HAZARD_WB_FORWARD_EN
    logic wb_wr_c;
    assign wb_wr_c = RegWrite_WB_i && (write_reg_WB_i != '0);
`else
    logic unused_wb;
    assign unused_wb = ^{RegWrite_WB_i, write_reg_WB_i};
`endif

    // Forwarding selects, priority EX > MEM > WB; "used" flags do not gate them.
    always_comb begin
        Asrc_o = SEL_RF;
        Bsrc_o = SEL_RF;
        if (ex_wr_c && (write_reg_EX_i == rs_i)) begin
            Asrc_o = SEL_EX;
        end else if (mem_wr_c && (write_reg_MEM_i == rs_i)) begin
            Asrc_o = SEL_MEM;
`ifdef HAZARD_WB_FORWARD_EN
        end else if (wb_wr_c && (write_reg_WB_i == rs_i)) begin
            Asrc_o = SEL_WB;
`endif
        end
        if (ex_wr_c && (write_reg_EX_i == rt_i)) begin
            Bsrc_o = SEL_EX;
        end else if (mem_wr_c && (write_reg_MEM_i == rt_i)) begin
            Bsrc_o = SEL_MEM;
`ifdef HAZARD_WB_FORWARD_EN
        end else if (wb_wr_c && (write_reg_WB_i == rt_i)) begin
            Bsrc_o = SEL_WB;
`endif
        end
    end

    // Hazard detection; a taken branch squashes ID, so it suppresses the stall.
    always_comb begin
        load_use_c = MemRead_EX_i && (write_reg_EX_i != '0) &&
                     (((write_reg_EX_i == rs_i) && rs_used_i) ||
                      ((write_reg_EX_i == rt_i) && rt_used_i));
        busy_c     = (busy_cnt_q != '0);
        mdu_haz_c  = busy_c && (mdu_use_i || mdu_start_i);
        stall_o    = (load_use_c || mdu_haz_c) && !branch_taken_i;
        flush_IFID_o = branch_taken_i;
        flush_IDEX_o = branch_taken_i;
    end

    // Next-state logic for the MDU tracker and the saturating stall counter.
    always_comb begin
        busy_cnt_d  = busy_cnt_q;
        stall_cnt_d = stall_cnt_q;

        if (rst_i) begin
            busy_cnt_d = '0;
        end else if (mdu_start_i && !stall_o && !branch_taken_i) begin
            busy_cnt_d = BUSY_W'(MDU_LAT);
        end else if (busy_cnt_q != '0) begin
            busy_cnt_d = busy_cnt_q - BUSY_W'(1);
        end

        if (rst_i || stall_cnt_clr_i) begin
            stall_cnt_d = '0;
        end else if (stall_o && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // State registers.
    always_ff @(posedge clk_i) begin
        busy_cnt_q  <= busy_cnt_d;
        stall_cnt_q <= stall_cnt_d;
    end

    assign mdu_busy_o  = (busy_cnt_q != '0);
    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_mips_hazard_unit.sv
// Scoreboard bench for mips_hazard_unit: the driver applies stimulus one cycle at a
// time and pushes the reference model's expected outputs; the monitor pops and
// compares them on the falling edge.
module tb_mips_hazard_unit;

    localparam int unsigned REG_AW  = 5;
    localparam int unsigned MDU_LAT = 4;
    localparam int unsigned CNT_W   = 4;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;

    typedef struct packed {
        logic              rst;
        logic [REG_AW-1:0] rs, rt;
        logic              rs_used, rt_used;
        logic [REG_AW-1:0] wex, wmem, wwb;
        logic              rwex, rwmem, rwwb, memrd;
        logic              start, mdu_use, bt, clr;
    } stim_t;

    typedef struct {
        logic [1:0] asrc, bsrc;
        logic       stall, flush, busy;
        int         cnt;
        string      tag;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_i;
    logic [REG_AW-1:0] rs_i, rt_i, write_reg_EX_i, write_reg_MEM_i, write_reg_WB_i;
    logic              rs_used_i, rt_used_i, RegWrite_EX_i, RegWrite_MEM_i, RegWrite_WB_i;
    logic              MemRead_EX_i, mdu_start_i, mdu_use_i, branch_taken_i, stall_cnt_clr_i;
    logic              stall_o, flush_IFID_o, flush_IDEX_o, mdu_busy_o;
    logic [1:0]        Asrc_o, Bsrc_o;
    logic [CNT_W-1:0]  stall_cnt_o;

    mips_hazard_unit #(.REG_AW(REG_AW), .MDU_LAT(MDU_LAT), .CNT_W(CNT_W)) dut (
        .clk_i(clk), .rst_i(rst_i), .rs_i(rs_i), .rt_i(rt_i),
        .rs_used_i(rs_used_i), .rt_used_i(rt_used_i),
        .write_reg_EX_i(write_reg_EX_i), .write_reg_MEM_i(write_reg_MEM_i),
        .write_reg_WB_i(write_reg_WB_i), .RegWrite_EX_i(RegWrite_EX_i),
        .RegWrite_MEM_i(RegWrite_MEM_i), .RegWrite_WB_i(RegWrite_WB_i),
        .MemRead_EX_i(MemRead_EX_i), .mdu_start_i(mdu_start_i), .mdu_use_i(mdu_use_i),
        .branch_taken_i(branch_taken_i), .stall_cnt_clr_i(stall_cnt_clr_i),
        .stall_o(stall_o), .flush_IFID_o(flush_IFID_o), .flush_IDEX_o(flush_IDEX_o),
        .Asrc_o(Asrc_o), .Bsrc_o(Bsrc_o), .mdu_busy_o(mdu_busy_o), .stall_cnt_o(stall_cnt_o)
    );

    always #5 clk = ~clk;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    bit   drv_done = 1'b0;

    // Reference state: remaining MDU busy cycles and the stall count.
    int mdu_left = 0;
    int cnt_m    = 0;

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        return s;
    endfunction

    // Forwarding source for one operand, derived from the stage rules.
    function automatic logic [1:0] ref_fwd(stim_t s, logic [REG_AW-1:0] op);
        if (op == 0) return 2'd0;
        if (s.rwex && s.wex == op) return 2'd1;
        if (s.rwmem && s.wmem == op) return 2'd2;
`ifdef HAZARD_WB_FORWARD_EN
        if (s.rwwb && s.wwb == op) return 2'd3;
`endif
        return 2'd0;
    endfunction

    task automatic apply(input stim_t s, input string tag);
        exp_t e;
        bit   lu, busy;
        @(posedge clk);
        #1;
        rst_i = s.rst; rs_i = s.rs; rt_i = s.rt; rs_used_i = s.rs_used; rt_used_i = s.rt_used;
        write_reg_EX_i = s.wex; write_reg_MEM_i = s.wmem; write_reg_WB_i = s.wwb;
        RegWrite_EX_i = s.rwex; RegWrite_MEM_i = s.rwmem; RegWrite_WB_i = s.rwwb;
        MemRead_EX_i = s.memrd; mdu_start_i = s.start; mdu_use_i = s.mdu_use;
        branch_taken_i = s.bt; stall_cnt_clr_i = s.clr;

        lu   = s.memrd && s.wex != 0 &&
               ((s.wex == s.rs && s.rs_used) || (s.wex == s.rt && s.rt_used));
        busy = (mdu_left > 0);
        e.asrc  = ref_fwd(s, s.rs);
        e.bsrc  = ref_fwd(s, s.rt);
        e.stall = (lu || (busy && (s.mdu_use || s.start))) && !s.bt;
        e.flush = s.bt;
        e.busy  = busy;
        e.cnt   = cnt_m;
        e.tag   = tag;
        q.push_back(e);

        // Advance the model across the next rising edge.
        if (s.rst) mdu_left = 0;
        else if (s.start && !e.stall && !s.bt) mdu_left = MDU_LAT;
        else if (mdu_left > 0) mdu_left--;
        if (s.rst || s.clr) cnt_m = 0;
        else if (e.stall && cnt_m < CNT_MAX) cnt_m++;
    endtask

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: compare every pending expectation at the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk({e.tag, ".Asrc"}, int'(Asrc_o), int'(e.asrc));
                chk({e.tag, ".Bsrc"}, int'(Bsrc_o), int'(e.bsrc));
                chk({e.tag, ".stall"}, int'(stall_o), int'(e.stall));
                chk({e.tag, ".flush_IFID"}, int'(flush_IFID_o), int'(e.flush));
                chk({e.tag, ".flush_IDEX"}, int'(flush_IDEX_o), int'(e.flush));
                chk({e.tag, ".busy"}, int'(mdu_busy_o), int'(e.busy));
                chk({e.tag, ".cnt"}, int'(stall_cnt_o), e.cnt);
            end
        end
    end

    initial begin
        stim_t s;
        // Hold reset across the first edge before any expectation is queued.
        s = idle(); s.rst = 1'b1;
        rst_i = 1'b1; rs_i = '0; rt_i = '0; rs_used_i = 0; rt_used_i = 0;
        write_reg_EX_i = '0; write_reg_MEM_i = '0; write_reg_WB_i = '0;
        RegWrite_EX_i = 0; RegWrite_MEM_i = 0; RegWrite_WB_i = 0; MemRead_EX_i = 0;
        mdu_start_i = 0; mdu_use_i = 0; branch_taken_i = 0; stall_cnt_clr_i = 0;
        apply(s, "reset0");
        apply(s, "reset1");

        // Forwarding priority EX over MEM, then MEM alone.
        s = idle(); s.rwex = 1; s.rwmem = 1; s.wex = 5; s.wmem = 5; s.rs = 5;
        apply(s, "fwd_ex");
        s.rwex = 0;
        apply(s, "fwd_mem");

        // Load-use on rt: used, unused, and destination r0.
        s = idle(); s.memrd = 1; s.rwex = 1; s.wex = 8; s.rt = 8; s.rt_used = 1;
        apply(s, "lu_used");
        s.rt_used = 0;
        apply(s, "lu_unused");
        s.rt_used = 1; s.wex = 0; s.rt = 0;
        apply(s, "lu_r0");

        // MDU: accepted start, then mfhi for five cycles (four stalls expected).
        s = idle(); s.start = 1;
        apply(s, "mdu_start");
        s = idle(); s.mdu_use = 1;
        for (int i = 0; i < 5; i++) apply(s, "mfhi");
        apply(idle(), "mdu_idle");

        // Taken branch overrides a load-use stall and blocks a concurrent mult.
        s = idle(); s.memrd = 1; s.wex = 8; s.rs = 8; s.rs_used = 1; s.bt = 1; s.start = 1;
        apply(s, "flush");
        apply(idle(), "flush_after");

        // Stall counter: clear, three stalls, then clear while stalling.
        s = idle(); s.clr = 1;
        apply(s, "cnt_clr0");
        s = idle(); s.memrd = 1; s.wex = 3; s.rs = 3; s.rs_used = 1;
        for (int i = 0; i < 3; i++) apply(s, "cnt_stall");
        s.clr = 1;
        apply(s, "cnt_clr_stall");
        apply(idle(), "cnt_after");
        // Saturation of the narrow counter.
        s.clr = 0;
        for (int i = 0; i < CNT_MAX + 3; i++) apply(s, "cnt_sat");
        apply(idle(), "cnt_hold");

        // WB forwarding, with no EX/MEM match.
        s = idle(); s.rwwb = 1; s.wwb = 9; s.rs = 9; s.rt = 9;
        apply(s, "fwd_wb");

        // Reset in the middle of an MDU operation.
        s = idle(); s.start = 1;
        apply(s, "rst_mdu_start");
        apply(idle(), "rst_mdu_busy");
        s = idle(); s.rst = 1;
        apply(s, "rst_mid");
        s = idle(); s.mdu_use = 1;
        apply(s, "rst_no_stall");

        // Back-to-back multiplies: stall while busy, then reload.
        s = idle(); s.start = 1;
        for (int i = 0; i < MDU_LAT + 3; i++) apply(s, "b2b_mult");

        // Randomized traffic over a small register range to provoke matches.
        for (int i = 0; i < 3000; i++) begin
            s = idle();
            s.rst     = ($urandom_range(0, 63) == 0);
            s.rs      = REG_AW'($urandom_range(0, 3));
            s.rt      = REG_AW'($urandom_range(0, 3));
            s.rs_used = 1'($urandom_range(0, 1));
            s.rt_used = 1'($urandom_range(0, 1));
            s.wex     = REG_AW'($urandom_range(0, 3));
            s.wmem    = REG_AW'($urandom_range(0, 3));
            s.wwb     = REG_AW'($urandom_range(0, 3));
            s.rwex    = 1'($urandom_range(0, 1));
            s.rwmem   = 1'($urandom_range(0, 1));
            s.rwwb    = 1'($urandom_range(0, 1));
            s.memrd   = ($urandom_range(0, 2) == 0);
            s.start   = ($urandom_range(0, 3) == 0);
            s.mdu_use = ($urandom_range(0, 3) == 0);
            s.bt      = ($urandom_range(0, 7) == 0);
            s.clr     = ($urandom_range(0, 31) == 0);
            apply(s, "rand");
        end
        drv_done = 1'b1;
    end

    // Finish once the driver is done and the scoreboard drains, bounded.
    initial begin
        wait (drv_done);
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) begin
            errors++;
            checks++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
